// File: rtl/gray_ptr_sync.sv
// Multi-stage synchroniser for a Gray-coded FIFO pointer crossing into clk.
// Outputs the pointer in Gray and binary form, with step size and a multi-bit-transition error monitor.
module gray_ptr_sync #(
  parameter int PTR_WIDTH = 4,
  parameter int STAGES    = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PTR_WIDTH:0]   d_gray,
  input  logic                 err_clr,
  output logic [PTR_WIDTH:0]   q_gray,
  output logic [PTR_WIDTH:0]   q_bin,
  output logic                 q_valid,
  output logic                 ptr_changed,
  output logic [PTR_WIDTH:0]   delta,
  output logic                 gray_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int W = PTR_WIDTH + 1;
  localparam logic [2:0] WARM_LAST = 3'(STAGES);

  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("gray_ptr_sync: STAGES must be in 2..4");
    end
  endgenerate

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Chain packed flat: stage 0 in the low W bits, last stage in the top W bits.
  logic [STAGES*W-1:0]  r_sync;
  logic [W-1:0]         r_q_gray;
  logic [W-1:0]         r_q_bin;
  logic                 r_q_valid;
  logic                 r_ptr_changed;
  logic [W-1:0]         r_delta;
  logic                 r_gray_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [2:0]           r_warm_cnt;

  logic [W-1:0] w_s;
  logic [W-1:0] w_s_bin;
  logic [W-1:0] w_diff;
  logic         w_moved;
  logic         w_illegal;

  assign w_s     = r_sync[STAGES*W-1 -: W];
  assign w_s_bin = gray2bin(w_s);
  assign w_diff  = w_s ^ r_q_gray;
  assign w_moved = r_q_valid && (w_diff != '0);
  // More than one bit set <=> clearing the lowest set bit leaves something behind.
  assign w_illegal = r_q_valid && ((w_diff & (w_diff - W'(1))) != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync        <= '0;
      r_q_gray      <= '0;
      r_q_bin       <= '0;
      r_q_valid     <= 1'b0;
      r_ptr_changed <= 1'b0;
      r_delta       <= '0;
      r_gray_err    <= 1'b0;
      r_err_cnt     <= '0;
      r_warm_cnt    <= '0;
    end else begin
      r_sync        <= {r_sync[(STAGES-1)*W-1:0], d_gray};
      r_q_gray      <= w_s;
      r_q_bin       <= w_s_bin;
      r_ptr_changed <= w_moved;
      r_delta       <= w_moved ? (w_s_bin - r_q_bin) : '0;

      if (!r_q_valid) begin
        if (r_warm_cnt == WARM_LAST) begin
          r_q_valid <= 1'b1;
        end else begin
          r_warm_cnt <= r_warm_cnt + 3'd1;
        end
      end

      // A fresh error outranks a simultaneous clear.
      if (w_illegal) begin
        r_gray_err <= 1'b1;
        if (err_clr) begin
          r_err_cnt <= ERR_CNT_W'(1);
        end else if (!(&r_err_cnt)) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end else if (err_clr) begin
        r_gray_err <= 1'b0;
        r_err_cnt  <= '0;
      end
    end
  end

  assign q_gray      = r_q_gray;
  assign q_bin       = r_q_bin;
  assign q_valid     = r_q_valid;
  assign ptr_changed = r_ptr_changed;
  assign delta       = r_delta;
  assign gray_err    = r_gray_err;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: table of per-edge vectors plus sequences for
// saturation, full-count wrap and mid-operation reset; STAGES=3/4 and ERR_CNT_W=2 copies run alongside.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_gray;
  logic       err_clr;

  logic [4:0] q_gray, q_bin, delta;
  logic       q_valid, ptr_changed, gray_err;
  logic [7:0] err_cnt;

  logic [4:0] q3_gray, q3_bin, q3_delta;
  logic       q3_valid, q3_chg, q3_err;
  logic [7:0] q3_cnt;

  logic [4:0] q4_gray, q4_bin, q4_delta;
  logic       q4_valid, q4_chg, q4_err;
  logic [7:0] q4_cnt;

  logic [4:0] qs_gray, qs_bin, qs_delta;
  logic       qs_valid, qs_chg, qs_err;
  logic [1:0] qs_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  gray_ptr_sync #(.PTR_WIDTH(4), .STAGES(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .d_gray(d_gray), .err_clr(err_clr),
    .q_gray(q_gray), .q_bin(q_bin), .q_valid(q_valid), .ptr_changed(ptr_changed),
    .delta(delta), .gray_err(gray_err), .err_cnt(err_cnt));

  gray_ptr_sync #(.PTR_WIDTH(4), .STAGES(3), .ERR_CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .d_gray(d_gray), .err_clr(err_clr),
    .q_gray(q3_gray), .q_bin(q3_bin), .q_valid(q3_valid), .ptr_changed(q3_chg),
    .delta(q3_delta), .gray_err(q3_err), .err_cnt(q3_cnt));

  gray_ptr_sync #(.PTR_WIDTH(4), .STAGES(4), .ERR_CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .d_gray(d_gray), .err_clr(err_clr),
    .q_gray(q4_gray), .q_bin(q4_bin), .q_valid(q4_valid), .ptr_changed(q4_chg),
    .delta(q4_delta), .gray_err(q4_err), .err_cnt(q4_cnt));

  gray_ptr_sync #(.PTR_WIDTH(4), .STAGES(2), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .d_gray(d_gray), .err_clr(err_clr),
    .q_gray(qs_gray), .q_bin(qs_bin), .q_valid(qs_valid), .ptr_changed(qs_chg),
    .delta(qs_delta), .gray_err(qs_err), .err_cnt(qs_cnt));

  typedef struct {
    logic       rst_n;
    logic       clr;
    logic [4:0] d;
    logic [4:0] q;
    logic [4:0] bin;
    logic       valid;
    logic       chg;
    logic [4:0] dlt;
    logic       err;
    logic [7:0] cnt;
    logic       chk34;
    logic [4:0] q3;
    logic [4:0] q4;
    logic       v3;
    logic       v4;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [4:0] eq, input logic [4:0] eb,
                          input logic ev, input logic ec, input logic [4:0] ed,
                          input logic ee, input logic [7:0] en);
    chk({tag, " q_gray"},      32'(q_gray),      32'(eq));
    chk({tag, " q_bin"},       32'(q_bin),       32'(eb));
    chk({tag, " q_valid"},     32'(q_valid),     32'(ev));
    chk({tag, " ptr_changed"}, 32'(ptr_changed), 32'(ec));
    chk({tag, " delta"},       32'(delta),       32'(ed));
    chk({tag, " gray_err"},    32'(gray_err),    32'(ee));
    chk({tag, " err_cnt"},     32'(err_cnt),     32'(en));
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] g;
    logic [4:0] exp_d;
    int         n_ill;

    rst_n   = 1'b0;
    d_gray  = '0;
    err_clr = 1'b0;

    // Fields: rst_n, clr, d | q, bin, valid, chg, delta, err, cnt | chk34, q3, q4, v3, v4
    vecs[0]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1,  1'b0, 8'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd1, 5'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd31, 1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 5'd3, 5'd3, 5'd2, 1'b1, 1'b1, 5'd2,  1'b1, 8'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 5'd2, 5'd3, 5'd2, 1'b1, 1'b0, 5'd0,  1'b1, 8'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 5'd2, 5'd3, 5'd2, 1'b1, 1'b0, 5'd0,  1'b1, 8'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 5'd2, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1,  1'b1, 8'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0,  1'b0, 8'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd30, 1'b1, 8'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0};

    // Reset/warm-up, latency, illegal step, clear and clear-vs-set collision.
    for (int i = 0; i < 22; i++) begin
      rst_n   = vecs[i].rst_n;
      err_clr = vecs[i].clr;
      d_gray  = vecs[i].d;
      edge_step();
      chk_main($sformatf("row%0d", i), vecs[i].q, vecs[i].bin, vecs[i].valid,
               vecs[i].chg, vecs[i].dlt, vecs[i].err, vecs[i].cnt);
      $display("vec %0d: d=%b q_gray=%b q_bin=%0d valid=%b chg=%b delta=%0d err=%b cnt=%0d",
               i, d_gray, q_gray, q_bin, q_valid, ptr_changed, delta, gray_err, err_cnt);
      if (vecs[i].chk34) begin
        chk($sformatf("row%0d s3 q_gray", i),  32'(q3_gray),  32'(vecs[i].q3));
        chk($sformatf("row%0d s4 q_gray", i),  32'(q4_gray),  32'(vecs[i].q4));
        chk($sformatf("row%0d s3 q_valid", i), 32'(q3_valid), 32'(vecs[i].v3));
        chk($sformatf("row%0d s4 q_valid", i), 32'(q4_valid), 32'(vecs[i].v4));
      end
    end

    // Saturation: clear, then five back-to-back illegal steps (00001 <-> 00010).
    d_gray  = 5'b00001;
    err_clr = 1'b1;
    edge_step();
    chk("sat clr err_cnt", 32'(qs_cnt), 32'd0);
    chk("sat clr gray_err", 32'(gray_err), 32'd0);
    err_clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d_gray = (k == 1 || k == 3) ? 5'b00001 : 5'b00010;
      edge_step();
      n_ill = (k < 2) ? 0 : ((k > 6) ? 5 : k - 1);
      exp_d = (k >= 2 && k <= 6) ? ((k % 2 == 0) ? 5'd2 : 5'd30) : 5'd0;
      chk($sformatf("sat%0d ptr_changed", k), 32'(ptr_changed), 32'(k >= 2 && k <= 6));
      chk($sformatf("sat%0d delta", k), 32'(delta), 32'(exp_d));
      chk($sformatf("sat%0d err_cnt", k), 32'(err_cnt), 32'(n_ill));
      chk($sformatf("sat%0d sat_cnt", k), 32'(qs_cnt), 32'((n_ill > 3) ? 3 : n_ill));
      $display("sat %0d: d=%b q_gray=%b chg=%b delta=%0d cnt=%0d sat_cnt=%0d",
               k, d_gray, q_gray, ptr_changed, delta, err_cnt, qs_cnt);
    end

    // Settle at Gray 0 with errors cleared (00010 -> 00000 is a legal one-bit step, bin 3 -> 0).
    d_gray  = 5'b00000;
    err_clr = 1'b1;
    edge_step();
    edge_step();
    edge_step();
    chk("settle q_bin", 32'(q_bin), 32'd0);
    chk("settle delta", 32'(delta), 32'd29);
    chk("settle gray_err", 32'(gray_err), 32'd0);
    err_clr = 1'b0;

    // Full-count wrap, one Gray step every two cycles; each change lands on the next step's first edge.
    for (int n = 1; n <= 32; n++) begin
      g = 5'(n % 32);
      d_gray = g ^ (g >> 1);
      edge_step();
      chk($sformatf("wrap%0d ptr_changed", n), 32'(ptr_changed), 32'(n > 1));
      chk($sformatf("wrap%0d q_bin", n), 32'(q_bin), 32'(n - 1));
      if (n > 1) chk($sformatf("wrap%0d delta", n), 32'(delta), 32'd1);
      chk($sformatf("wrap%0d gray_err", n), 32'(gray_err), 32'd0);
      $display("wrap %0d: d=%b q_gray=%b q_bin=%0d chg=%b delta=%0d", n, d_gray, q_gray, q_bin, ptr_changed, delta);
      edge_step();
      chk($sformatf("wrap%0d hold ptr_changed", n), 32'(ptr_changed), 32'd0);
    end
    edge_step();
    chk_main("wrap end", 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b0, 8'd0);

    // Raise an error, put a step in flight, then reset for one edge.
    d_gray = 5'b00011;
    edge_step();
    edge_step();
    edge_step();
    chk_main("pre-reset illegal", 5'b00011, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 8'd1);
    d_gray = 5'b00001;
    edge_step();
    rst_n  = 1'b0;
    d_gray = 5'b10110;
    edge_step();
    chk_main("midreset", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
    chk("midreset sat_cnt", 32'(qs_cnt), 32'd0);
    chk("midreset s4 q_gray", 32'(q4_gray), 32'd0);
    $display("midreset: q_gray=%b valid=%b err=%b cnt=%0d", q_gray, q_valid, gray_err, err_cnt);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_step();
      if (k < 3) chk_main($sformatf("rewarm%0d", k), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0);
      else       chk_main($sformatf("rewarm%0d", k), 5'b10110, 5'd27, 1'b1, 1'b0, 5'd0, 1'b0, 8'd0);
      $display("rewarm %0d: q_gray=%b q_bin=%0d valid=%b chg=%b err=%b", k, q_gray, q_bin, q_valid, ptr_changed, gray_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
